// File: rtl/uart_pkg.sv
// Shared types for the pattern-generating UART transmitter: FSM states and MODE encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'b00,
        MODE_FIXED  = 2'b01,
        MODE_STREAM = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

endpackage

// File: rtl/uart_pattern_tx_baud_tick_gen.sv
// Baud divider: counts 0..CLK_DIV-1 and flags the last cycle of every bit period.
module baud_tick_gen #(
    parameter int CLK_DIV = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    // Clearing on a frame start aligns the bit grid to the take cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_pattern_tx.sv
// UART transmitter with built-in byte source (counter pattern, fixed byte or stream).
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_pattern_tx
    import uart_pkg::*;
#(
    parameter int         CLK_DIV    = 26,
    parameter int         DATA_BITS  = 8,
    parameter int         STOP_BITS  = 1,
    parameter logic [7:0] PAT_LO     = 8'h30,
    parameter logic [7:0] PAT_HI     = 8'h39,
    parameter int         PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [DATA_BITS-1:0] fixed_byte,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 txd,
    output logic                 idle,
    output logic                 byte_sent,
    output logic [15:0]          tx_count
);

    localparam logic [DATA_BITS-1:0] PAT_LO_T  = PAT_LO[DATA_BITS-1:0];
    localparam logic [DATA_BITS-1:0] PAT_HI_T  = PAT_HI[DATA_BITS-1:0];
    localparam logic [2:0]           BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic                 STOP_LAST = 1'(STOP_BITS - 1);

    if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PAT_HI < PAT_LO || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_pattern_tx: illegal parameter combination");
    end

    state_t               state;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] pat_cnt;
    logic [DATA_BITS-1:0] src_byte;
    logic [2:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 tick;
    logic                 frame_end;
    logic                 take_pos;
    logic                 src_ok;
    logic                 take;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    baud_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (take),
        .tick  (tick)
    );

    // A new byte may be taken while idle or in the very last stop-bit cycle,
    // which is what lets frames run back-to-back without an idle gap.
    always_comb begin
        frame_end = (state == ST_STOP) && tick && (stop_cnt == STOP_LAST);
        take_pos  = (state == ST_IDLE) || frame_end;
        src_ok    = 1'b0;
        src_byte  = pat_cnt;
        case (mode)
            MODE_COUNT:  begin src_ok = 1'b1;    src_byte = pat_cnt;    end
            MODE_FIXED:  begin src_ok = 1'b1;    src_byte = fixed_byte; end
            MODE_STREAM: begin src_ok = s_valid; src_byte = s_data;     end
            default:     begin src_ok = 1'b0;    src_byte = pat_cnt;    end
        endcase
        take = take_pos && en && src_ok;
    end

    assign s_ready   = take_pos && en && (mode == MODE_STREAM);
    assign byte_sent = frame_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            txd      <= 1'b1;
            idle     <= 1'b1;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            pat_cnt  <= PAT_LO_T;
            tx_count <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (frame_end) begin
                tx_count <= tx_count + 16'd1;
            end
            if (take) begin
                state    <= ST_START;
                txd      <= 1'b0;
                idle     <= 1'b0;
                shift    <= src_byte;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
                parity_bit <= (^src_byte) ^ 1'(PARITY_ODD);
`endif
                if (mode == MODE_COUNT) begin
                    pat_cnt <= (pat_cnt == PAT_HI_T) ? PAT_LO_T : pat_cnt + 1'b1;
                end
            end else if (tick) begin
                case (state)
                    ST_IDLE: begin
                        txd <= 1'b1;
                    end
                    ST_START: begin
                        state <= ST_DATA;
                        txd   <= shift[0];
                    end
                    ST_DATA: begin
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            txd   <= parity_bit;
`else
                            state <= ST_STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        state <= ST_STOP;
                        txd   <= 1'b1;
                    end
`endif
                    ST_STOP: begin
                        if (stop_cnt == STOP_LAST) begin
                            state <= ST_IDLE;
                            idle  <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        txd   <= 1'b1;
                        idle  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_pattern_tx.sv
// Directed bench for uart_pattern_tx with default parameters (no parity build).
module tb_uart_pattern_tx;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  fixed_byte;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        txd;
    logic        idle;
    logic        byte_sent;
    logic [15:0] tx_count;

    int compared   = 0;
    int mismatched = 0;
    int bs_count   = 0;
    int hs_count   = 0;
    int bs_base;
    int hs_base;

    uart_pattern_tx dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .fixed_byte (fixed_byte),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .txd        (txd),
        .idle       (idle),
        .byte_sent  (byte_sent),
        .tx_count   (tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent tallies of completion pulses and stream handshakes.
    always @(posedge clk) begin
        if (byte_sent === 1'b1) bs_count <= bs_count + 1;
        if (s_ready === 1'b1 && s_valid === 1'b1) hs_count <= hs_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge of the take cycle; returns at the negedge of the final stop-bit cycle.
    task automatic applyStimulus(input logic [7:0] exp_byte, input logic [15:0] exp_count,
                                 input bit drop_en, input string tag);
        checkOutput({tag, "_pre_txd"}, 16'(txd), 16'd1);
        @(negedge clk);
        checkOutput({tag, "_start_edge"}, 16'(txd), 16'd0);
        checkOutput({tag, "_busy"}, 16'(idle), 16'd0);
        repeat (12) @(negedge clk);
        checkOutput({tag, "_start_mid"}, 16'(txd), 16'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (26) @(negedge clk);
            if (drop_en && i == 4) en = 1'b0;
            checkOutput($sformatf("%s_d%0d", tag, i), 16'(txd), 16'(exp_byte[i]));
        end
        repeat (26) @(negedge clk);
        checkOutput({tag, "_stop"}, 16'(txd), 16'd1);
        checkOutput({tag, "_no_early_sent"}, 16'(byte_sent), 16'd0);
        checkOutput({tag, "_ready_mid"}, 16'(s_ready), 16'd0);
        repeat (13) @(negedge clk);
        checkOutput({tag, "_sent"}, 16'(byte_sent), 16'd1);
        checkOutput({tag, "_count"}, tx_count, exp_count);
    endtask

    initial begin
        logic [7:0] pat;
        rst = 1'b1; en = 1'b1; mode = 2'b00;
        fixed_byte = 8'h00; s_data = 8'hA5; s_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_txd", 16'(txd), 16'd1);
        checkOutput("rst_idle", 16'(idle), 16'd1);
        checkOutput("rst_ready", 16'(s_ready), 16'd0);
        checkOutput("rst_sent", 16'(byte_sent), 16'd0);
        checkOutput("rst_count", tx_count, 16'd0);

        // Counter pattern: '0'..'9' then '0' again, back-to-back.
        rst = 1'b0;
        pat = 8'h30;
        for (int k = 0; k < 11; k++) begin
            applyStimulus(pat, 16'(k), 1'b0, $sformatf("cnt%0d", k));
            pat = (pat == 8'h39) ? 8'h30 : pat + 8'd1;
        end
        mode = 2'b11;
        @(negedge clk);
        checkOutput("hold_idle", 16'(idle), 16'd1);
        checkOutput("hold_txd", 16'(txd), 16'd1);
        checkOutput("hold_count", tx_count, 16'd11);

        // Stream: ready offered while idle, two frames with no gap.
        mode = 2'b10;
        repeat (20) @(negedge clk);
        checkOutput("str_wait_txd", 16'(txd), 16'd1);
        checkOutput("str_wait_idle", 16'(idle), 16'd1);
        checkOutput("str_wait_ready", 16'(s_ready), 16'd1);
        hs_base = hs_count;
        s_valid = 1'b1;
        applyStimulus(8'hA5, 16'd11, 1'b0, "str0");
        applyStimulus(8'hA5, 16'd12, 1'b0, "str1");
        s_valid = 1'b0;
        @(negedge clk);
        checkOutput("str_handshakes", 16'(hs_count - hs_base), 16'd2);
        checkOutput("str_idle", 16'(idle), 16'd1);

        // Fixed byte with EN dropped mid-data: frame completes once, then idle.
        mode = 2'b01; fixed_byte = 8'h55;
        bs_base = bs_count;
        applyStimulus(8'h55, 16'd13, 1'b1, "fix");
        repeat (2) @(negedge clk);
        checkOutput("fix_idle", 16'(idle), 16'd1);
        repeat (50) @(negedge clk);
        checkOutput("fix_txd_quiet", 16'(txd), 16'd1);
        checkOutput("fix_sent_once", 16'(bs_count - bs_base), 16'd1);
        checkOutput("fix_count", tx_count, 16'd14);

        // Reset during data bit 4 abandons the frame; counter pattern restarts at '0'.
        mode = 2'b00; en = 1'b1;
        bs_base = bs_count;
        repeat (135) @(negedge clk);
        checkOutput("abort_bit4", 16'(txd), 16'(pat[4]));
        #1 rst = 1'b1;
        #1;
        checkOutput("abort_txd", 16'(txd), 16'd1);
        checkOutput("abort_count", tx_count, 16'd0);
        checkOutput("abort_idle", 16'(idle), 16'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h30, 16'd0, 1'b1, "post_rst");
        @(negedge clk);
        checkOutput("post_rst_idle", 16'(idle), 16'd1);
        checkOutput("post_rst_sent", 16'(bs_count - bs_base), 16'd1);
        checkOutput("post_rst_count", tx_count, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
